sccb_config_seq: RTL and testbench

SCCB_CONFIG_SEQ -- requirements
Module: sccb_config_seq

---
 rtl/sccb_config_seq_pkg.sv | 64 ++++++
 rtl/ov7670_cfg_rom.sv | 29 ++
 rtl/sccb_config_seq.sv | 134 +++++++++++++
 tb/tb_sccb_config_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_config_seq_pkg.sv
// ============================================================================
// sccb_config_seq_pkg -- markers, state encoding and register tables
// Rev 1.0
// ============================================================================
`default_nettype none

package sccb_config_seq_pkg;

    localparam logic [15:0] END_MARK  = 16'hFFFF;
    localparam logic [15:0] DLY_MARK  = 16'hFFF0;
    localparam logic [7:0]  COM7_ADDR = 8'h12;
    localparam int unsigned ACK_TRIES = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_ACK  = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_DELAY     = 3'd6,
        S_FINISH    = 3'd7
    } state_t;

    // OV7670 bring-up: soft reset, settle, then RGB565 at QVGA.
    localparam int unsigned OV7670_N = 30;
    localparam logic [15:0] OV7670_TBL [OV7670_N] = '{
        {COM7_ADDR, 8'h80}, DLY_MARK,     {COM7_ADDR, 8'h14}, 16'h8C00,
        16'h0400,           16'h40D0,     16'h3A04,           16'h1418,
        16'h4FB3,           16'h50B3,     16'h5100,           16'h523D,
        16'h53A7,           16'h54E4,     16'h589E,           16'h3DC0,
        16'h1100,           16'h0C04,     16'h3E19,           16'h7211,
        16'h73F1,           16'h1716,     16'h1804,           16'h3224,
        16'h1902,           16'h1A7A,     16'h030A,           16'h703A,
        16'h7135,           END_MARK
    };

    // sel 0 is the production table; 1..3 are short bring-up tables.
    function automatic logic [15:0] rom_entry(input int unsigned sel, input int unsigned idx);
        logic [15:0] v;
        v = END_MARK;
        case (sel)
            1: if (idx == 0) v = 16'h1122;
            2: case (idx)
                   0:       v = {COM7_ADDR, 8'h80};
                   1:       v = DLY_MARK;
                   2:       v = 16'h3A04;
                   default: v = END_MARK;
               endcase
            3: case (idx)
                   0:       v = 16'h2101;
                   1:       v = 16'h2202;
                   2:       v = 16'h2303;
                   3:       v = 16'h2404;
                   default: v = END_MARK;
               endcase
            default: if (idx < OV7670_N) v = OV7670_TBL[idx[4:0]];
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ov7670_cfg_rom.sv
// ============================================================================
// ov7670_cfg_rom -- register table with one-cycle registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module ov7670_cfg_rom
    import sccb_config_seq_pkg::*;
#(
    parameter int unsigned ROM_AW  = 8,
    parameter int unsigned ROM_SEL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROM_AW-1:0] addr,
    output logic [15:0]       data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= rom_entry(ROM_SEL, 32'(addr));
        end
    end

endmodule

`default_nettype wire

// File: rtl/sccb_config_seq.sv
// ============================================================================
// sccb_config_seq -- walks the camera register table and feeds an SCCB writer
// Rev 1.0
// ============================================================================
`default_nettype none

module sccb_config_seq
    import sccb_config_seq_pkg::*;
#(
    parameter int unsigned DEV_F    = 50_000_000,
    parameter int unsigned DELAY_MS = 10,
    parameter int unsigned ROM_AW   = 8,
    parameter int unsigned ROM_SEL  = 0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_fGo,
    input  logic              i_Ready,
    output logic [7:0]        o_Addr,
    output logic [7:0]        o_Data,
    output logic              o_fStart,
    output logic              o_Busy,
    output logic              o_fDone,
    output logic [ROM_AW-1:0] o_Idx
);

    localparam int unsigned       DLY_CYC  = DEV_F / 1000 * DELAY_MS;
    localparam int unsigned       DLY_W    = (DLY_CYC > 0) ? $clog2(DLY_CYC + 1) : 1;
    localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'((DLY_CYC > 0) ? DLY_CYC - 1 : 0);
    localparam logic [ROM_AW-1:0] IDX_LAST = '1;
    localparam logic [1:0]        ACK_LAST = 2'(ACK_TRIES - 1);

    state_t           state;
    logic [15:0]      rom_q;
    logic [DLY_W-1:0] dly_cnt;
    logic [1:0]       ack_cnt;

    ov7670_cfg_rom #(
        .ROM_AW  (ROM_AW),
        .ROM_SEL (ROM_SEL)
    ) u_rom (
        .clk   (i_Clk),
        .rst_n (i_Rst),
        .addr  (o_Idx),
        .data  (rom_q)
    );

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state    <= S_IDLE;
            o_Addr   <= '0;
            o_Data   <= '0;
            o_fStart <= 1'b0;
            o_Busy   <= 1'b0;
            o_fDone  <= 1'b0;
            o_Idx    <= '0;
            dly_cnt  <= '0;
            ack_cnt  <= '0;
        end else begin
            o_fStart <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_fGo) begin
                        o_Idx   <= '0;
                        o_Busy  <= 1'b1;
                        o_fDone <= 1'b0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (rom_q == END_MARK) begin
                        state <= S_FINISH;
                    end else if (rom_q == DLY_MARK) begin
                        dly_cnt <= '0;
                        state   <= S_DELAY;
                    end else begin
                        o_Addr <= rom_q[15:8];
                        o_Data <= rom_q[7:0];
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_Ready) begin
                        o_fStart <= 1'b1;
                        ack_cnt  <= '0;
                        state    <= S_WAIT_ACK;
                    end
                end
                // A writer that never drops ready missed the request; ask again.
                S_WAIT_ACK: begin
                    if (!i_Ready) begin
                        state <= S_WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        state <= S_ISSUE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_Ready) begin
                        if (o_Idx == IDX_LAST) begin
                            state <= S_FINISH;
                        end else begin
                            o_Idx <= o_Idx + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_cnt == DLY_LAST) begin
                        if (o_Idx == IDX_LAST) begin
                            state <= S_FINISH;
                        end else begin
                            o_Idx <= o_Idx + 1'b1;
                            state <= S_FETCH;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    o_Busy  <= 1'b0;
                    o_fDone <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sccb_config_seq.sv
// ============================================================================
// tb_sccb_config_seq -- directed checks of the register-table sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sccb_config_seq;

    localparam int BUSY_LEN = 100;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] go;
    logic [3:0] ready = 4'hF;

    logic [3:0]      start_v;
    logic [3:0]      busy_v;
    logic [3:0]      done_v;
    logic [3:0][7:0] addr_v;
    logic [3:0][7:0] data_v;
    logic [3:0][7:0] idx_v;
    logic [1:0]      idx_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // 0: table {1122,FFFF}; 1: {1280,FFF0,3A04,FFFF} with 100-cycle delay;
    // 2: four writes, no end marker, 2-bit index; 3: production table.
    sccb_config_seq #(.DEV_F(100_000), .DELAY_MS(1), .ROM_AW(8), .ROM_SEL(1)) u_a (
        .i_Clk(clk), .i_Rst(rst_n), .i_fGo(go[0]), .i_Ready(ready[0]),
        .o_Addr(addr_v[0]), .o_Data(data_v[0]), .o_fStart(start_v[0]),
        .o_Busy(busy_v[0]), .o_fDone(done_v[0]), .o_Idx(idx_v[0]));

    sccb_config_seq #(.DEV_F(100_000), .DELAY_MS(1), .ROM_AW(8), .ROM_SEL(2)) u_b (
        .i_Clk(clk), .i_Rst(rst_n), .i_fGo(go[1]), .i_Ready(ready[1]),
        .o_Addr(addr_v[1]), .o_Data(data_v[1]), .o_fStart(start_v[1]),
        .o_Busy(busy_v[1]), .o_fDone(done_v[1]), .o_Idx(idx_v[1]));

    sccb_config_seq #(.DEV_F(100_000), .DELAY_MS(1), .ROM_AW(2), .ROM_SEL(3)) u_c (
        .i_Clk(clk), .i_Rst(rst_n), .i_fGo(go[2]), .i_Ready(ready[2]),
        .o_Addr(addr_v[2]), .o_Data(data_v[2]), .o_fStart(start_v[2]),
        .o_Busy(busy_v[2]), .o_fDone(done_v[2]), .o_Idx(idx_c));

    assign idx_v[2] = {6'd0, idx_c};

    sccb_config_seq #(.DEV_F(10_000), .DELAY_MS(1), .ROM_AW(8), .ROM_SEL(0)) u_d (
        .i_Clk(clk), .i_Rst(rst_n), .i_fGo(go[3]), .i_Ready(ready[3]),
        .o_Addr(addr_v[3]), .o_Data(data_v[3]), .o_fStart(start_v[3]),
        .o_Busy(busy_v[3]), .o_fDone(done_v[3]), .o_Idx(idx_v[3]));

    // Monitors: start pulses, done rises, index going backwards mid-pass.
    int         n_start [4] = '{0, 0, 0, 0};
    int         n_done  [4] = '{0, 0, 0, 0};
    logic [3:0] done_q  = '0;
    logic [3:0] busy_q  = '0;
    logic [3:0][7:0] idx_q = '0;
    logic [3:0] idx_dec = '0;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (start_v[k]) n_start[k] <= n_start[k] + 1;
            if (done_v[k] && !done_q[k]) n_done[k] <= n_done[k] + 1;
            if (busy_v[k] && busy_q[k] && (idx_v[k] < idx_q[k])) idx_dec[k] <= 1'b1;
        end
        done_q <= done_v;
        busy_q <= busy_v;
        idx_q  <= idx_v;
    end

    // SCCB writer model: drops ready 2 cycles after a start, raises it
    // BUSY_LEN cycles later. Starts numbered below ign_upto are ignored.
    int ign_upto [4] = '{0, 0, 0, 0};
    int phase    [4] = '{0, 0, 0, 0};
    int cnt      [4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                phase[k] <= 0;
                cnt[k]   <= 0;
                ready[k] <= 1'b1;
            end else begin
                case (phase[k])
                    0: if (start_v[k] && (n_start[k] >= ign_upto[k])) begin
                           phase[k] <= 1;
                           cnt[k]   <= 1;
                       end
                    1: if (cnt[k] == 2) begin
                           ready[k] <= 1'b0;
                           phase[k] <= 2;
                           cnt[k]   <= 1;
                       end else begin
                           cnt[k] <= cnt[k] + 1;
                       end
                    default: if (cnt[k] == BUSY_LEN) begin
                           ready[k] <= 1'b1;
                           phase[k] <= 0;
                       end else begin
                           cnt[k] <= cnt[k] + 1;
                       end
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_go(input int k);
        @(negedge clk);
        go[k] = 1'b1;
        @(negedge clk);
        go[k] = 1'b0;
    endtask

    task automatic wait_start(input int k, input int budget, input string tag, output int cyc);
        @(negedge clk);
        cyc = 1;
        while (!start_v[k] && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(start_v[k]), 32'd1);
    endtask

    task automatic wait_done(input int k, input int budget, input string tag);
        int c;
        c = 0;
        while (!done_v[k] && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(done_v[k]), 32'd1);
    endtask

    initial begin
        int cyc;
        int base;
        int base_d;

        rst_n = 1'b0;
        go    = '0;
        repeat (3) @(negedge clk);
        check("rst_start", 32'(start_v[0]), 32'd0);
        check("rst_busy",  32'(busy_v[0]),  32'd0);
        check("rst_done",  32'(done_v[0]),  32'd0);
        check("rst_addr",  32'(addr_v[0]),  32'd0);
        check("rst_data",  32'(data_v[0]),  32'd0);
        check("rst_idx",   32'(idx_v[0]),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write then end marker
        base = n_start[0];
        pulse_go(0);
        check("go_busy", 32'(busy_v[0]), 32'd1);
        check("go_done", 32'(done_v[0]), 32'd0);
        wait_start(0, 50, "w1_start_seen", cyc);
        check("w1_addr", 32'(addr_v[0]), 32'h11);
        check("w1_data", 32'(data_v[0]), 32'h22);
        check("w1_idx",  32'(idx_v[0]),  32'd0);
        wait_done(0, 400, "w1_done_seen");
        check("w1_busy_end", 32'(busy_v[0]), 32'd0);
        repeat (3) @(negedge clk);
        check("w1_nstart", 32'(n_start[0] - base), 32'd1);

        // Writer ignores the first request: re-pulse 5 negedges later
        base = n_start[0];
        ign_upto[0] = base + 1;
        pulse_go(0);
        check("rp_done_clr", 32'(done_v[0]), 32'd0);
        wait_start(0, 50, "rp_first_seen", cyc);
        wait_start(0, 20, "rp_second_seen", cyc);
        check("rp_gap",  32'(cyc),         32'd5);
        check("rp_addr", 32'(addr_v[0]),   32'h11);
        check("rp_data", 32'(data_v[0]),   32'h22);
        wait_done(0, 400, "rp_done_seen");
        repeat (3) @(negedge clk);
        check("rp_nstart", 32'(n_start[0] - base), 32'd2);

        // No end marker, 2-bit index, extra go mid-pass
        base   = n_start[2];
        base_d = n_done[2];
        pulse_go(2);
        wait_start(2, 50, "nw_start0", cyc);
        check("nw_addr0", 32'(addr_v[2]), 32'h21);
        check("nw_data0", 32'(data_v[2]), 32'h01);
        wait_start(2, 300, "nw_start1", cyc);
        check("nw_data1", 32'(data_v[2]), 32'h02);
        wait_start(2, 300, "nw_start2", cyc);
        check("nw_addr2", 32'(addr_v[2]), 32'h23);
        pulse_go(2);
        check("nw_busy_mid", 32'(busy_v[2]), 32'd1);
        check("nw_idx_mid",  32'(idx_v[2]),  32'd2);
        wait_start(2, 300, "nw_start3", cyc);
        check("nw_addr3", 32'(addr_v[2]), 32'h24);
        check("nw_data3", 32'(data_v[2]), 32'h04);
        wait_done(2, 400, "nw_done_seen");
        check("nw_busy_end", 32'(busy_v[2]), 32'd0);
        check("nw_idx_end",  32'(idx_v[2]),  32'd3);
        repeat (3) @(negedge clk);
        check("nw_nstart", 32'(n_start[2] - base),  32'd4);
        check("nw_ndone",  32'(n_done[2] - base_d), 32'd1);
        check("nw_idx_mono", 32'(idx_dec[2]), 32'd0);

        // Delay marker: 2 fetch/decode + 100 delay + fetch/decode/issue cycles
        pulse_go(1);
        wait_start(1, 50, "dl_start0", cyc);
        check("dl_addr0", 32'(addr_v[1]), 32'h12);
        cyc = 0;
        while (ready[1] && cyc < 50) begin @(negedge clk); cyc++; end
        while (!ready[1] && cyc < 300) begin @(negedge clk); cyc++; end
        check("dl_ready_back", 32'(ready[1]), 32'd1);
        wait_start(1, 400, "dl_start1", cyc);
        check("dl_gap_min", 32'(cyc >= 100), 32'd1);
        check("dl_gap",     32'(cyc),        32'd106);
        check("dl_addr1",   32'(addr_v[1]),  32'h3A);
        check("dl_data1",   32'(data_v[1]),  32'h04);
        wait_done(1, 400, "dl_done_seen");

        // Production table: COM7 soft reset, delay, then COM7 = RGB/QVGA
        pulse_go(3);
        wait_start(3, 50, "ov_start0", cyc);
        check("ov_addr0", 32'(addr_v[3]), 32'h12);
        check("ov_data0", 32'(data_v[3]), 32'h80);
        wait_start(3, 400, "ov_start1", cyc);
        check("ov_addr1", 32'(addr_v[3]), 32'h12);
        check("ov_data1", 32'(data_v[3]), 32'h14);

        // Reset while waiting for the writer to finish
        pulse_go(0);
        wait_start(0, 50, "rs_start", cyc);
        cyc = 0;
        while (ready[0] && cyc < 50) begin @(negedge clk); cyc++; end
        repeat (2) @(negedge clk);
        check("rs_busy_pre", 32'(busy_v[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_addr",  32'(addr_v[0]),  32'd0);
        check("rs_data",  32'(data_v[0]),  32'd0);
        check("rs_start0", 32'(start_v[0]), 32'd0);
        check("rs_busy",  32'(busy_v[0]),  32'd0);
        check("rs_done",  32'(done_v[0]),  32'd0);
        check("rs_idx",   32'(idx_v[0]),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = n_start[0];
        repeat (10) @(negedge clk);
        check("rs_idle_start", 32'(start_v[0]), 32'd0);
        check("rs_idle_busy",  32'(busy_v[0]),  32'd0);
        check("rs_idle_nst",   32'(n_start[0] - base), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
